cmd_rx_queue: RTL

- Command ingress stage: receives serial bytes from the host UART line, frames them, and buffers them in a first-word-fall-through byte queue.
- The queue's data/empty/pop port feeds the instruction decoder's read-queue interface directly.
- Flags framing errors and overflows as sticky bits so firmware and the verification bench can detect lost command bytes.

---
 rtl/cmd_pkg.sv | 19 +
 rtl/uart_rx.sv | 132 +++++++++++++
 rtl/cmd_rx_queue.sv | 83 ++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Shared types and defaults for the command ingress path (UART receiver + byte queue).
// Latency: n/a (types only).
// Backpressure: n/a.
package cmd_pkg;

  localparam int CLKS_PER_BIT_DEF = 104;
  localparam int DEPTH_DEF        = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-flop synchronizer, mid-bit sampling FSM, 8N1 or 8E1 when RX_PARITY_EN is defined.
// Latency: byte_vld pulses one cycle after the stop-bit sample.
// Backpressure: none; the consumer must accept byte_vld in the cycle it is asserted.
module uart_rx
  import cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       err_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta;
  logic          rx_s;
  logic          rx_s_q;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  byte_t         shreg;
  logic          par_bad;

  // Flops reset high so a reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_q  <= rx_s;
    end
  end

`ifdef RX_PARITY_EN
  logic par_err;
  assign par_bad = par_err;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      byte_vld  <= 1'b0;
      err_pulse <= 1'b0;
`ifdef RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      byte_vld  <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_s_q && !rx_s) begin
            state   <= RX_START;
            cnt     <= '0;
            bit_cnt <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_BIT) begin
            cnt   <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
`ifdef RX_PARITY_EN
            par_err <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_BIT) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef RX_PARITY_EN
        RX_PARITY: begin
          if (cnt == FULL_BIT) begin
            cnt     <= '0;
            par_err <= (^shreg) != rx_s;
            state   <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          // Return to IDLE at mid stop bit so a back-to-back start edge is caught.
          if (cnt == FULL_BIT) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s && !par_bad) begin
              byte_vld <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              err_pulse <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cmd_rx_queue.sv
// Command ingress: UART receiver feeding a FWFT byte queue with sticky overflow/frame_err (parity via RX_PARITY_EN).
// Latency: byte visible on q_data the edge after the receiver push strobe; pop effective at the q_pop edge.
// Backpressure: none toward the line; a byte arriving at a full queue without a pop is dropped and flagged.
module cmd_rx_queue
  import cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DEPTH        = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  output logic [7:0]               q_data,
  output logic                     q_empty,
  input  logic                     q_pop,
  output logic                     q_full,
  output logic [$clog2(DEPTH):0]   q_level,
  output logic                     overflow,
  output logic                     frame_err,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);

  byte_t       rx_byte;
  logic        byte_vld;
  logic        err_pulse;
  byte_t       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;
  logic        drop;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_vld  (byte_vld),
    .err_pulse (err_pulse)
  );

  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign q_level = wr_ptr - rd_ptr;
  assign q_data  = q_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  // A same-cycle pop frees the slot, so a push into a full queue still lands.
  assign do_pop  = q_pop && !q_empty;
  assign do_push = byte_vld && (!q_full || do_pop);
  assign drop    = byte_vld && q_full && !do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  // A new error in the clear cycle keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (err_pulse)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule
